cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control FSM that sequences the 16-bit CPU datapath: fetch, IR load, execute, and a stall state for the iterative divide/modulo unit. It sits beside the register/ALU/RAM datapath and drives its load strobes and ALU op select. It adds free-run and single-step control, a divide watchdog, and a retired-instruction counter.

## Interface
Parameters
- DIV_TIMEOUT, 32: maximum DIVWAIT cycles before watchdog halt (range 2..255)

Ports
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- run  in  1  level; 1 = free-running execution
- step  in  1  single-instruction request; rising edge is detected internally
- ir_opcode  in  4  IR[15:12] from datapath; valid in EXEC
- div_done  in  1  iterative divider result valid (level)
- fetch_en  out  1  load RAM address register from PC
- ir_load  out  1  load IR from RAM data
- pc_inc  out  1  PC <= PC + 1
- rega_load  out  1  REG_A <= input register
- regb_load  out  1  REG_B <= input register
- alu_en  out  1  latch ALU result
- alu_op  out  3  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD; 0 when idle
- flags_load  out  1  latch Zero/Carry
- led_load  out  1  out_led <= REG_A
- div_start  out  1  one-cycle divider start pulse
- halted  out  1  FSM in HALT
- error  out  1  sticky; HALT entered via watchdog
- state  out  3  current state encoding (debug)
- instr_count  out  16  retired-instruction counter

## Operation
- States: IDLE=0, FETCH=1, LOADIR=2, EXEC=3, DIVWAIT=4, HALT=5. Codes 6 and 7 go to IDLE next cycle.
- Strobes are combinational from the registered state and ir_opcode. halted, error, state and instr_count are registered.
- step_evt = step & ~step_q, where step_q is step registered each cycle.
- IDLE: no strobes. Go to FETCH if run or step_evt, else stay.
- FETCH: fetch_en=1. Go to LOADIR.
- LOADIR: ir_load=1, pc_inc=1. Go to EXEC.
- EXEC decode on ir_opcode:
  - 1: rega_load.
  - 2: regb_load.
  - 3, 5, 6: alu_en and flags_load, with alu_op 0, 1 or 2 respectively.
  - 4: led_load.
  - 7 or 8: div_start=1, alu_op 3 or 4; go to DIVWAIT and clear the watchdog counter.
  - F: go to HALT.
  - Any other opcode: NOP.
- Non-divide EXEC, including F, retires the instruction: instr_count+1. Next state is HALT for F, else FETCH if run, else IDLE.
- DIVWAIT: alu_op holds the divide op latched at EXEC.
  - div_done=1: alu_en=1, flags_load=1, retire. Next state FETCH if run, else IDLE.
  - div_done=0: counter increments. When the counter reaches DIV_TIMEOUT-1 with no done, set error=1 and go to HALT; the instruction does not retire.
  - div_done wins when it coincides with the timeout cycle.
- HALT: halted=1 and all strobes 0. Only reset exits.
- div_done outside DIVWAIT is ignored.
- step_evt outside IDLE is discarded, not queued.
- run dropping mid-instruction: the instruction completes, then the FSM enters IDLE.
- instr_count wraps 0xFFFF -> 0x0000.

## Timing
- Reset (synchronous), at the next clk edge in any state, including mid-DIVWAIT:
  - state=IDLE, step_q=0, error=0, halted=0, instr_count=0, watchdog counter=0.
  - All strobes read 0 and alu_op=0 from that edge on.
- Single-cycle instruction: 3 cycles (FETCH, LOADIR, EXEC). Back-to-back under run=1 gives one retire per 3 cycles.
- DIV/MOD: 3 cycles + k DIVWAIT cycles, where div_done first seen on DIVWAIT cycle k (k>=1). div_start fires exactly once, in EXEC.
- Single step from IDLE: step_evt edge, then FETCH on the next cycle; back in IDLE 3 cycles later.
- Watchdog: HALT entered after DIV_TIMEOUT DIVWAIT cycles without done.
- instr_count updates on the edge that leaves EXEC/DIVWAIT.

## Test plan
- Reset, then run=1 with opcode stream 1,2,3 → strobes rega_load, regb_load, then alu_en+flags_load with alu_op=0 on cycles 3, 6, 9; instr_count=3 after cycle 9.
- Opcode 7, div_done raised on the 5th DIVWAIT cycle → div_start exactly once; alu_en+alu_op=3 in that same cycle; instruction total 8 cycles; instr_count+1.
- Opcode 8, div_done held 0, DIV_TIMEOUT=32 → HALT after 32 DIVWAIT cycles, error=1, halted=1, instr_count unchanged. run/step ignored until reset; reset clears all outputs.
- run=0, step held high for 20 cycles → exactly one instruction executes; second pulse after a low cycle executes one more.
- Opcode F under run=1 → halted=1 one cycle after EXEC, instr_count+1, no further fetch_en.
- Reset asserted mid-DIVWAIT with div_done=1 in the same cycle → IDLE, no alu_en, instr_count=0. instr_count preloaded to 0xFFFF via 65535 NOPs wraps to 0 on the next retire.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the 16-bit CPU datapath.
// Walks FETCH -> LOADIR -> EXEC (-> DIVWAIT) per instruction, drives the
// datapath load strobes and ALU op select, and adds run/single-step control,
// a divide watchdog and a retired-instruction counter.
module cpu_sequencer #(
  parameter int DIV_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic [3:0]  ir_opcode,
  input  logic        div_done,
  output logic        fetch_en,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        rega_load,
  output logic        regb_load,
  output logic        alu_en,
  output logic [2:0]  alu_op,
  output logic        flags_load,
  output logic        led_load,
  output logic        div_start,
  output logic        halted,
  output logic        error,
  output logic [2:0]  state,
  output logic [15:0] instr_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LOADIR  = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_DIVWAIT = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_OUT  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_MUL  = 4'h6;
  localparam logic [3:0] OP_DIV  = 4'h7;
  localparam logic [3:0] OP_MOD  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_MUL = 3'd2;
  localparam logic [2:0] ALU_DIV = 3'd3;
  localparam logic [2:0] ALU_MOD = 3'd4;

  // Last watchdog count value; DIVWAIT cycle k sees count k-1.
  localparam logic [7:0] WDOG_LAST = 8'(DIV_TIMEOUT - 1);

  logic [2:0]  r_state;
  logic        r_step_q;
  logic [7:0]  r_wdog;
  logic [2:0]  r_div_op;
  logic        r_halted;
  logic        r_error;
  logic [15:0] r_instr_count;

  logic [2:0]  w_next_state;
  logic        w_step_evt;
  logic        w_retire;
  logic        w_timeout;
  logic        w_div_enter;

  assign w_step_evt  = step & ~r_step_q;
  assign w_div_enter = (r_state == S_EXEC) && (w_next_state == S_DIVWAIT);

  assign state       = r_state;
  assign halted      = r_halted;
  assign error       = r_error;
  assign instr_count = r_instr_count;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode, plus retire/timeout qualifiers for the counters.
  always_comb begin
    w_next_state = S_IDLE;
    w_retire     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE:   w_next_state = (run || w_step_evt) ? S_FETCH : S_IDLE;
      S_FETCH:  w_next_state = S_LOADIR;
      S_LOADIR: w_next_state = S_EXEC;
      S_EXEC: begin
        if (ir_opcode == OP_DIV || ir_opcode == OP_MOD) begin
          w_next_state = S_DIVWAIT;
        end else begin
          w_retire     = 1'b1;
          w_next_state = (ir_opcode == OP_HALT) ? S_HALT : (run ? S_FETCH : S_IDLE);
        end
      end
      S_DIVWAIT: begin
        if (div_done) begin
          w_retire     = 1'b1;
          w_next_state = run ? S_FETCH : S_IDLE;
        end else if (r_wdog == WDOG_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_DIVWAIT;
        end
      end
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Datapath strobes, decoded from the registered state and current opcode.
  always_comb begin
    fetch_en   = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    rega_load  = 1'b0;
    regb_load  = 1'b0;
    alu_en     = 1'b0;
    alu_op     = ALU_ADD;
    flags_load = 1'b0;
    led_load   = 1'b0;
    div_start  = 1'b0;
    case (r_state)
      S_FETCH:  fetch_en = 1'b1;
      S_LOADIR: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
      end
      S_EXEC: begin
        case (ir_opcode)
          OP_LDA: rega_load = 1'b1;
          OP_LDB: regb_load = 1'b1;
          OP_OUT: led_load  = 1'b1;
          OP_ADD, OP_SUB, OP_MUL: begin
            alu_en     = 1'b1;
            flags_load = 1'b1;
            alu_op     = (ir_opcode == OP_ADD) ? ALU_ADD :
                         (ir_opcode == OP_SUB) ? ALU_SUB : ALU_MUL;
          end
          OP_DIV, OP_MOD: begin
            div_start = 1'b1;
            alu_op    = (ir_opcode == OP_DIV) ? ALU_DIV : ALU_MOD;
          end
          default: ;
        endcase
      end
      S_DIVWAIT: begin
        alu_op     = r_div_op;
        alu_en     = div_done;
        flags_load = div_done;
      end
      default: ;
    endcase
  end

  // Step edge history, divide op latch, watchdog, sticky flags, retire count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_step_q      <= 1'b0;
      r_wdog        <= 8'd0;
      r_div_op      <= ALU_ADD;
      r_halted      <= 1'b0;
      r_error       <= 1'b0;
      r_instr_count <= 16'd0;
    end else begin
      r_step_q <= step;
      r_halted <= (w_next_state == S_HALT);
      if (w_div_enter) begin
        r_wdog   <= 8'd0;
        r_div_op <= (ir_opcode == OP_DIV) ? ALU_DIV : ALU_MOD;
      end else if (r_state == S_DIVWAIT && !div_done) begin
        r_wdog <= r_wdog + 8'd1;
      end
      if (w_timeout) r_error <= 1'b1;
      if (w_retire)  r_instr_count <= r_instr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer: a per-cycle vector table for the
// regular instruction flow, plus hand-written sequences for step hold,
// divide watchdog, reset during DIVWAIT and counter wrap.
module tb_cpu_sequencer;

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_LOADIR = 2, ST_EXEC = 3, ST_DIVWAIT = 4, ST_HALT = 5;

  // Strobe vector order: fetch_en, ir_load, pc_inc, rega, regb, alu_en, flags, led, div_start
  localparam logic [8:0] SB_0   = 9'b000000000;
  localparam logic [8:0] SB_F   = 9'b100000000;
  localparam logic [8:0] SB_L   = 9'b011000000;
  localparam logic [8:0] SB_A   = 9'b000100000;
  localparam logic [8:0] SB_B   = 9'b000010000;
  localparam logic [8:0] SB_ALU = 9'b000001100;
  localparam logic [8:0] SB_LED = 9'b000000010;
  localparam logic [8:0] SB_DIV = 9'b000000001;

  logic        clk = 1'b0;
  logic        reset, run, step, div_done;
  logic [3:0]  ir_opcode;
  logic        fetch_en, ir_load, pc_inc, rega_load, regb_load, alu_en;
  logic [2:0]  alu_op;
  logic        flags_load, led_load, div_start, halted, error;
  logic [2:0]  state;
  logic [15:0] instr_count;
  logic [8:0]  strb;

  assign strb = {fetch_en, ir_load, pc_inc, rega_load, regb_load, alu_en, flags_load, led_load, div_start};

  cpu_sequencer #(.DIV_TIMEOUT(32)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .ir_opcode(ir_opcode),
    .div_done(div_done), .fetch_en(fetch_en), .ir_load(ir_load), .pc_inc(pc_inc),
    .rega_load(rega_load), .regb_load(regb_load), .alu_en(alu_en), .alu_op(alu_op),
    .flags_load(flags_load), .led_load(led_load), .div_start(div_start),
    .halted(halted), .error(error), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, run, step, done;
    logic [3:0]  op;
    logic [2:0]  st;
    logic [8:0]  strb;
    logic [2:0]  aop;
    logic        halt, err;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input int r, input int ru, input int s, input int o, input int d,
                     input int st, input logic [8:0] sb, input int aop,
                     input int h, input int e, input int c);
    vec_t v;
    v.rst = (r != 0); v.run = (ru != 0); v.step = (s != 0); v.done = (d != 0);
    v.op = 4'(o); v.st = 3'(st); v.strb = sb; v.aop = 3'(aop);
    v.halt = (h != 0); v.err = (e != 0); v.cnt = 16'(c);
    vq.push_back(v);
  endtask

  // Apply inputs mid-cycle; outputs are sampled 1 time unit later.
  task automatic drive(input int r, input int ru, input int s, input int o, input int d);
    @(negedge clk);
    reset = (r != 0); run = (ru != 0); step = (s != 0);
    ir_opcode = 4'(o); div_done = (d != 0);
    #1;
  endtask

  task automatic chk_ctl(input string nm, input int st, input int h, input int e, input int c);
    chk({nm, "_state"}, 32'(state), 32'(st));
    chk({nm, "_halted"}, 32'(halted), 32'(h));
    chk({nm, "_error"}, 32'(error), 32'(e));
    chk({nm, "_count"}, 32'(instr_count), 32'(c));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int fetches, dw_seen;
    reset = 1'b1; run = 1'b0; step = 1'b0; ir_opcode = 4'h0; div_done = 1'b0;

    //   rst run stp op  done  state       strobes aop hlt err cnt
    add(0, 1, 0, 0,   0, ST_IDLE,    SB_0,   0, 0, 0, 0);
    add(0, 1, 0, 0,   0, ST_FETCH,   SB_F,   0, 0, 0, 0);
    add(0, 1, 0, 0,   0, ST_LOADIR,  SB_L,   0, 0, 0, 0);
    add(0, 1, 0, 1,   0, ST_EXEC,    SB_A,   0, 0, 0, 0);
    add(0, 1, 0, 0,   0, ST_FETCH,   SB_F,   0, 0, 0, 1);
    add(0, 1, 0, 0,   0, ST_LOADIR,  SB_L,   0, 0, 0, 1);
    add(0, 1, 0, 2,   0, ST_EXEC,    SB_B,   0, 0, 0, 1);
    add(0, 1, 0, 0,   0, ST_FETCH,   SB_F,   0, 0, 0, 2);
    add(0, 1, 0, 0,   0, ST_LOADIR,  SB_L,   0, 0, 0, 2);
    add(0, 1, 0, 3,   0, ST_EXEC,    SB_ALU, 0, 0, 0, 2);
    add(0, 1, 0, 0,   0, ST_FETCH,   SB_F,   0, 0, 0, 3);
    add(0, 1, 0, 0,   0, ST_LOADIR,  SB_L,   0, 0, 0, 3);
    add(0, 0, 0, 5,   0, ST_EXEC,    SB_ALU, 1, 0, 0, 3);   // run drops: finish, go IDLE
    add(0, 0, 0, 0,   0, ST_IDLE,    SB_0,   0, 0, 0, 4);
    add(0, 0, 1, 0,   0, ST_IDLE,    SB_0,   0, 0, 0, 4);   // step edge
    add(0, 0, 1, 0,   0, ST_FETCH,   SB_F,   0, 0, 0, 4);
    add(0, 0, 1, 0,   0, ST_LOADIR,  SB_L,   0, 0, 0, 4);
    add(0, 0, 1, 6,   0, ST_EXEC,    SB_ALU, 2, 0, 0, 4);
    add(0, 0, 1, 0,   0, ST_IDLE,    SB_0,   0, 0, 0, 5);   // step still high: no edge
    add(0, 0, 0, 0,   0, ST_IDLE,    SB_0,   0, 0, 0, 5);
    add(0, 0, 1, 0,   0, ST_IDLE,    SB_0,   0, 0, 0, 5);   // new edge
    add(0, 0, 0, 0,   0, ST_FETCH,   SB_F,   0, 0, 0, 5);
    add(0, 0, 0, 0,   0, ST_LOADIR,  SB_L,   0, 0, 0, 5);
    add(0, 0, 0, 4,   0, ST_EXEC,    SB_LED, 0, 0, 0, 5);
    add(0, 1, 0, 0,   0, ST_IDLE,    SB_0,   0, 0, 0, 6);
    add(0, 1, 0, 0,   0, ST_FETCH,   SB_F,   0, 0, 0, 6);
    add(0, 1, 0, 0,   0, ST_LOADIR,  SB_L,   0, 0, 0, 6);
    add(0, 1, 0, 0,   0, ST_EXEC,    SB_0,   0, 0, 0, 6);   // NOP opcode 0
    add(0, 0, 1, 0,   0, ST_FETCH,   SB_F,   0, 0, 0, 7);   // step edge outside IDLE
    add(0, 0, 0, 0,   0, ST_LOADIR,  SB_L,   0, 0, 0, 7);
    add(0, 0, 0, 11,  0, ST_EXEC,    SB_0,   0, 0, 0, 7);   // NOP opcode B
    add(0, 0, 0, 0,   0, ST_IDLE,    SB_0,   0, 0, 0, 8);   // discarded step
    add(0, 0, 0, 0,   0, ST_IDLE,    SB_0,   0, 0, 0, 8);
    add(0, 1, 0, 0,   0, ST_IDLE,    SB_0,   0, 0, 0, 8);
    add(0, 1, 0, 0,   0, ST_FETCH,   SB_F,   0, 0, 0, 8);
    add(0, 1, 0, 0,   0, ST_LOADIR,  SB_L,   0, 0, 0, 8);
    add(0, 1, 0, 7,   0, ST_EXEC,    SB_DIV, 3, 0, 0, 8);
    add(0, 1, 0, 0,   0, ST_DIVWAIT, SB_0,   3, 0, 0, 8);   // op held from EXEC
    add(0, 1, 0, 0,   0, ST_DIVWAIT, SB_0,   3, 0, 0, 8);
    add(0, 1, 0, 0,   0, ST_DIVWAIT, SB_0,   3, 0, 0, 8);
    add(0, 1, 0, 0,   0, ST_DIVWAIT, SB_0,   3, 0, 0, 8);
    add(0, 0, 0, 0,   1, ST_DIVWAIT, SB_ALU, 3, 0, 0, 8);   // done on 5th DIVWAIT
    add(0, 0, 0, 0,   1, ST_IDLE,    SB_0,   0, 0, 0, 9);   // stray done ignored
    add(0, 1, 0, 0,   0, ST_IDLE,    SB_0,   0, 0, 0, 9);
    add(0, 1, 0, 0,   0, ST_FETCH,   SB_F,   0, 0, 0, 9);
    add(0, 1, 0, 0,   0, ST_LOADIR,  SB_L,   0, 0, 0, 9);
    add(0, 1, 0, 8,   0, ST_EXEC,    SB_DIV, 4, 0, 0, 9);
    add(0, 1, 0, 8,   1, ST_DIVWAIT, SB_ALU, 4, 0, 0, 9);   // k = 1
    add(0, 1, 0, 0,   0, ST_FETCH,   SB_F,   0, 0, 0, 10);
    add(0, 1, 0, 0,   0, ST_LOADIR,  SB_L,   0, 0, 0, 10);
    add(0, 1, 0, 15,  0, ST_EXEC,    SB_0,   0, 0, 0, 10);  // HALT opcode
    add(0, 1, 1, 0,   0, ST_HALT,    SB_0,   0, 1, 0, 11);
    add(0, 1, 0, 0,   0, ST_HALT,    SB_0,   0, 1, 0, 11);
    add(1, 1, 0, 0,   0, ST_HALT,    SB_0,   0, 1, 0, 11);
    add(0, 0, 0, 0,   0, ST_IDLE,    SB_0,   0, 0, 0, 0);

    // Reset state
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk_ctl("reset", ST_IDLE, 0, 0, 0);
    chk("reset_strobes", 32'(strb), 32'(SB_0));
    chk("reset_aluop", 32'(alu_op), 32'd0);

    // Vector table
    for (int i = 0; i < vq.size(); i++) begin
      drive(int'(vq[i].rst), int'(vq[i].run), int'(vq[i].step), int'(vq[i].op), int'(vq[i].done));
      chk($sformatf("row%0d_state", i),  32'(state),       32'(vq[i].st));
      chk($sformatf("row%0d_strobe", i), 32'(strb),        32'(vq[i].strb));
      chk($sformatf("row%0d_aluop", i),  32'(alu_op),      32'(vq[i].aop));
      chk($sformatf("row%0d_halted", i), 32'(halted),      32'(vq[i].halt));
      chk($sformatf("row%0d_error", i),  32'(error),       32'(vq[i].err));
      chk($sformatf("row%0d_count", i),  32'(instr_count), 32'(vq[i].cnt));
    end

    // Step held high for 20 cycles: one instruction; next pulse: one more
    fetches = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 1, 0);
      if (fetch_en) fetches++;
    end
    chk("step_hold_fetches", 32'(fetches), 32'd1);
    chk_ctl("step_hold", ST_IDLE, 0, 0, 1);
    drive(0, 0, 0, 1, 0);
    fetches = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 1, 0);
      if (fetch_en) fetches++;
    end
    chk("step_second_fetches", 32'(fetches), 32'd1);
    chk_ctl("step_second", ST_IDLE, 0, 0, 2);

    // done coinciding with the 32nd DIVWAIT cycle wins over the watchdog
    drive(0, 0, 0, 8, 0);
    drive(0, 1, 0, 8, 0);
    drive(0, 1, 0, 8, 0);
    drive(0, 1, 0, 8, 0);
    drive(0, 1, 0, 8, 0);
    chk("coinc_div_start", 32'(div_start), 32'd1);
    for (int i = 0; i < 31; i++) drive(0, 1, 0, 8, 0);
    drive(0, 0, 0, 8, 1);
    chk("coinc_dw32_state", 32'(state), 32'(ST_DIVWAIT));
    chk("coinc_dw32_alu", 32'({alu_en, alu_op}), 32'({1'b1, 3'd4}));
    drive(0, 0, 0, 0, 0);
    chk_ctl("coinc_after", ST_IDLE, 0, 0, 3);

    // Watchdog timeout: 32 DIVWAIT cycles without done -> HALT, error
    drive(0, 1, 0, 7, 0);
    drive(0, 1, 0, 7, 0);
    drive(0, 1, 0, 7, 0);
    drive(0, 1, 0, 7, 0);
    dw_seen = 0;
    for (int i = 0; i < 32; i++) begin
      drive(0, 1, 0, 7, 0);
      if (state == 3'(ST_DIVWAIT) && !alu_en && !div_start) dw_seen++;
    end
    chk("wdog_dw_cycles", 32'(dw_seen), 32'd32);
    drive(0, 1, 0, 7, 0);
    chk_ctl("wdog_halt", ST_HALT, 1, 1, 3);
    fetches = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, i % 2, 1, 1);
      if (fetch_en || state != 3'(ST_HALT)) fetches++;
    end
    chk("wdog_stuck", 32'(fetches), 32'd0);
    drive(1, 1, 0, 7, 0);
    drive(0, 0, 0, 7, 0);
    chk_ctl("wdog_reset", ST_IDLE, 0, 0, 0);
    chk("wdog_reset_strobes", 32'({strb, alu_op}), 32'd0);

    // Reset mid-DIVWAIT while div_done is high
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 7, 0);
    drive(0, 1, 0, 7, 0);
    drive(0, 1, 0, 7, 0);
    drive(0, 1, 0, 7, 0);
    chk_ctl("rstdiv_dw1", ST_DIVWAIT, 0, 0, 1);
    drive(1, 1, 0, 7, 1);
    drive(0, 0, 0, 7, 1);
    chk_ctl("rstdiv_after", ST_IDLE, 0, 0, 0);
    chk("rstdiv_strobes", 32'({strb, alu_op}), 32'd0);

    // Counter wrap: preload 0xFFFF, retire one NOP
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    force dut.r_instr_count = 16'hFFFF;
    #1;
    release dut.r_instr_count;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 9, 0);
    chk_ctl("wrap_exec", ST_EXEC, 0, 0, 16'hFFFF);
    drive(0, 0, 0, 0, 0);
    chk_ctl("wrap_after", ST_IDLE, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
